// File: rtl/branch_train_unit.sv
// Tournament branch predictor training unit: owns local/global/choice PHTs and the committed
// global history, applies one retiring-branch update per cycle and serves a combinational fetch lookup.
module branch_train_unit #(
  parameter int IDX_W  = 8,
  parameter int HIST_W = 8,
  parameter int PC_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              MD_train_vaild_i,
  input  logic              MD_jal_i,
  input  logic              MD_train_taken_i,
  input  logic              MD_train_predict_i,
  input  logic              MD_train_global_predict_i,
  input  logic              MD_train_local_predict_i,
  input  logic [HIST_W-1:0] MD_train_global_history_i,
  input  logic [PC_W-1:0]   MD_PC_i,
  input  logic [PC_W-1:0]   F_PC_i,
  input  logic [HIST_W-1:0] F_history_i,
  output logic              F_predict_o,
  output logic              F_global_predict_o,
  output logic              F_local_predict_o,
  output logic              init_done_o,
  output logic              mispredict_o,
  output logic [HIST_W-1:0] recover_history_o,
  output logic [HIST_W-1:0] commit_history_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int FOLD_W = (IDX_W < HIST_W) ? IDX_W : HIST_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_cnt;

  logic [1:0] lpht [DEPTH];
  logic [1:0] gpht [DEPTH];
  logic [1:0] cpht [DEPTH];

  function automatic logic [IDX_W-1:0] fold_hist(input logic [HIST_W-1:0] h);
    logic [IDX_W-1:0] r;
    r = '0;
    r[FOLD_W-1:0] = h[FOLD_W-1:0];
    return r;
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Choice moves toward whichever component alone got the direction right.
  function automatic logic [1:0] choice_next(input logic [1:0] c, input logic g_ok,
                                             input logic l_ok);
    if (g_ok && !l_ok) return sat_inc(c);
    if (!g_ok && l_ok) return sat_dec(c);
    return c;
  endfunction

  logic             train_go;
  logic             md_miss;
  logic [IDX_W-1:0] md_lidx;
  logic [IDX_W-1:0] md_gidx;

  assign train_go = (state == RUN) && MD_train_vaild_i && !MD_jal_i;
  assign md_miss  = MD_train_predict_i != MD_train_taken_i;
  assign md_lidx  = MD_PC_i[IDX_W+1:2];
  assign md_gidx  = md_lidx ^ fold_hist(MD_train_global_history_i);

  // ---- p0 -> p1: retiring branch captured into the update register ----
  logic             vld_p1;
  logic [IDX_W-1:0] lidx_p1;
  logic [IDX_W-1:0] gidx_p1;
  logic             taken_p1;
  logic             gpred_p1;
  logic             lpred_p1;

  always_ff @(posedge clk_i) begin
    if (train_go) begin
      lidx_p1  <= md_lidx;
      gidx_p1  <= md_gidx;
      taken_p1 <= MD_train_taken_i;
      gpred_p1 <= MD_train_global_predict_i;
      lpred_p1 <= MD_train_local_predict_i;
    end
  end

  // ---- p1: read-modify-write of the three tables ----
  logic [1:0] lnew_p1;
  logic [1:0] gnew_p1;
  logic [1:0] cnew_p1;

  always_comb begin
    lnew_p1 = taken_p1 ? sat_inc(lpht[lidx_p1]) : sat_dec(lpht[lidx_p1]);
    gnew_p1 = taken_p1 ? sat_inc(gpht[gidx_p1]) : sat_dec(gpht[gidx_p1]);
    cnew_p1 = choice_next(cpht[lidx_p1], gpred_p1 == taken_p1, lpred_p1 == taken_p1);
  end

  always_ff @(posedge clk_i) begin
    if (state == INIT) begin
      lpht[init_cnt] <= 2'b01;
      gpht[init_cnt] <= 2'b01;
      cpht[init_cnt] <= 2'b10;
    end else if (vld_p1) begin
      lpht[lidx_p1] <= lnew_p1;
      gpht[gidx_p1] <= gnew_p1;
      cpht[lidx_p1] <= cnew_p1;
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state             <= INIT;
      init_cnt          <= '0;
      init_done_o       <= 1'b0;
      vld_p1            <= 1'b0;
      mispredict_o      <= 1'b0;
      recover_history_o <= '0;
      commit_history_o  <= '0;
    end else begin
      vld_p1            <= train_go;
      mispredict_o      <= train_go && md_miss;
      recover_history_o <= (train_go && md_miss) ?
                           {MD_train_global_history_i[HIST_W-2:0], MD_train_taken_i} : '0;
      if (vld_p1) commit_history_o <= {commit_history_o[HIST_W-2:0], taken_p1};
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (&init_cnt) begin
            state       <= RUN;
            init_done_o <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Fetch lookup; an in-flight update to the same entry is forwarded over the stale array value.
  logic [IDX_W-1:0] f_lidx;
  logic [IDX_W-1:0] f_gidx;
  logic [1:0]       f_lcnt;
  logic [1:0]       f_gcnt;
  logic [1:0]       f_ccnt;
  logic             run;

  assign run    = state == RUN;
  assign f_lidx = F_PC_i[IDX_W+1:2];
  assign f_gidx = f_lidx ^ fold_hist(F_history_i);
  assign f_lcnt = (vld_p1 && f_lidx == lidx_p1) ? lnew_p1 : lpht[f_lidx];
  assign f_gcnt = (vld_p1 && f_gidx == gidx_p1) ? gnew_p1 : gpht[f_gidx];
  assign f_ccnt = (vld_p1 && f_lidx == lidx_p1) ? cnew_p1 : cpht[f_lidx];

  assign F_local_predict_o  = run && f_lcnt[1];
  assign F_global_predict_o = run && f_gcnt[1];
  assign F_predict_o        = run && (f_ccnt[1] ? f_gcnt[1] : f_lcnt[1]);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{MD_PC_i[PC_W-1:IDX_W+2], MD_PC_i[1:0],
                            F_PC_i[PC_W-1:IDX_W+2], F_PC_i[1:0],
                            MD_train_global_history_i[HIST_W-1]};

endmodule

// File: tb/tb_branch_train_unit.sv
// Directed bench for branch_train_unit: init sequencing, training vectors, saturation,
// choice selection, lookup forwarding, jal, and reset mid-run with re-initialisation.
module tb_branch_train_unit;
  localparam int IDX_W  = 8;
  localparam int HIST_W = 8;
  localparam int PC_W   = 32;

  logic              clk_i = 1'b0;
  logic              rst;
  logic              MD_train_vaild_i, MD_jal_i, MD_train_taken_i, MD_train_predict_i;
  logic              MD_train_global_predict_i, MD_train_local_predict_i;
  logic [HIST_W-1:0] MD_train_global_history_i;
  logic [PC_W-1:0]   MD_PC_i, F_PC_i;
  logic [HIST_W-1:0] F_history_i;
  logic              F_predict_o, F_global_predict_o, F_local_predict_o;
  logic              init_done_o, mispredict_o;
  logic [HIST_W-1:0] recover_history_o, commit_history_o;

  always #5 clk_i = ~clk_i;

  branch_train_unit #(.IDX_W(IDX_W), .HIST_W(HIST_W), .PC_W(PC_W)) dut (
    .clk_i(clk_i), .rst(rst),
    .MD_train_vaild_i(MD_train_vaild_i), .MD_jal_i(MD_jal_i),
    .MD_train_taken_i(MD_train_taken_i), .MD_train_predict_i(MD_train_predict_i),
    .MD_train_global_predict_i(MD_train_global_predict_i),
    .MD_train_local_predict_i(MD_train_local_predict_i),
    .MD_train_global_history_i(MD_train_global_history_i),
    .MD_PC_i(MD_PC_i), .F_PC_i(F_PC_i), .F_history_i(F_history_i),
    .F_predict_o(F_predict_o), .F_global_predict_o(F_global_predict_o),
    .F_local_predict_o(F_local_predict_o), .init_done_o(init_done_o),
    .mispredict_o(mispredict_o), .recover_history_o(recover_history_o),
    .commit_history_o(commit_history_o)
  );

  typedef struct {
    logic        jal;
    logic [31:0] pc;
    logic [7:0]  hist;
    logic        tk, pr, gp, lp;
    logic        exp_mis;
    logic [7:0]  exp_rec;
    logic [7:0]  exp_commit;
    logic [31:0] fpc;
    logic [7:0]  fhist;
    logic        exp_l, exp_g, exp_p;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_train(input logic jal, input logic [31:0] pc, input logic [7:0] hist,
                           input logic tk, input logic pr, input logic gp, input logic lp);
    MD_train_vaild_i          = 1'b1;
    MD_jal_i                  = jal;
    MD_PC_i                   = pc;
    MD_train_global_history_i = hist;
    MD_train_taken_i          = tk;
    MD_train_predict_i        = pr;
    MD_train_global_predict_i = gp;
    MD_train_local_predict_i  = lp;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [7:0] hist, input string tag,
                        input logic el, input logic eg, input logic ep);
    F_PC_i      = pc;
    F_history_i = hist;
    #1;
    chk({tag, ".local"}, F_local_predict_o, el);
    chk({tag, ".global"}, F_global_predict_o, eg);
    chk({tag, ".predict"}, F_predict_o, ep);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'h40,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 32'h40,  8'h00, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h40,  8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 32'h40,  8'h00, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 32'h80,  8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 32'h80,  8'h02, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h80,  8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 8'h07, 32'h80,  8'h02, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 32'h80,  8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0F, 32'h80,  8'h02, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h1E, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h100, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h4A, 8'h3C, 32'h100, 8'hA5, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    MD_train_vaild_i = 1'b0; MD_jal_i = 1'b0; MD_train_taken_i = 1'b0;
    MD_train_predict_i = 1'b0; MD_train_global_predict_i = 1'b0;
    MD_train_local_predict_i = 1'b0; MD_train_global_history_i = '0;
    MD_PC_i = '0; F_PC_i = 32'h40; F_history_i = '0;
    tick(); tick();
    chk("rst.init_done", init_done_o, 1'b0);
    chk("rst.mispredict", mispredict_o, 1'b0);
    chk("rst.recover", recover_history_o, 8'h00);
    chk("rst.commit", commit_history_o, 8'h00);
    chk("rst.predict", F_predict_o, 1'b0);

    @(negedge clk_i) rst = 1'b0;
    repeat (255) @(posedge clk_i);
    #1;
    chk("init.done_at_255", init_done_o, 1'b0);
    chk("init.predict_gated", F_predict_o, 1'b0);
    tick();
    chk("init.done_at_256", init_done_o, 1'b1);
    lookup(32'h123, 8'h00, "init_lookup", 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      set_train(vecs[i].jal, vecs[i].pc, vecs[i].hist, vecs[i].tk, vecs[i].pr,
                vecs[i].gp, vecs[i].lp);
      tick();
      MD_train_vaild_i = 1'b0;
      chk($sformatf("vec%0d.mispredict", i), mispredict_o, vecs[i].exp_mis);
      chk($sformatf("vec%0d.recover", i), recover_history_o, vecs[i].exp_rec);
      tick();
      chk($sformatf("vec%0d.commit", i), commit_history_o, vecs[i].exp_commit);
      lookup(vecs[i].fpc, vecs[i].fhist, $sformatf("vec%0d", i),
             vecs[i].exp_l, vecs[i].exp_g, vecs[i].exp_p);
    end

    // Five back-to-back taken trainings to one entry, then two not-taken.
    set_train(1'b0, 32'h200, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    MD_train_vaild_i = 1'b0;
    tick();
    chk("sat.commit5", commit_history_o, 8'h9F);
    lookup(32'h200, 8'h00, "sat.after5", 1'b1, 1'b1, 1'b1);
    set_train(1'b0, 32'h200, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    MD_train_vaild_i = 1'b0;
    chk("sat.nt_mispredict", mispredict_o, 1'b1);
    chk("sat.nt_recover", recover_history_o, 8'h00);
    tick();
    chk("sat.commit6", commit_history_o, 8'h3E);
    lookup(32'h200, 8'h00, "sat.after_nt1", 1'b1, 1'b1, 1'b1);
    set_train(1'b0, 32'h200, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    MD_train_vaild_i = 1'b0;
    tick();
    chk("sat.commit7", commit_history_o, 8'h7C);
    lookup(32'h200, 8'h00, "sat.after_nt2", 1'b0, 1'b0, 1'b0);

    // Lookup in the same cycle as the in-flight update must see the new counter.
    set_train(1'b0, 32'h300, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    MD_train_vaild_i = 1'b0;
    lookup(32'h300, 8'h00, "fwd.same", 1'b1, 1'b1, 1'b1);
    lookup(32'h304, 8'h00, "fwd.other", 1'b0, 1'b0, 1'b0);
    tick();
    lookup(32'h300, 8'h00, "fwd.array", 1'b1, 1'b1, 1'b1);
    chk("fwd.commit", commit_history_o, 8'hF9);

    set_train(1'b1, 32'h40, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    MD_train_vaild_i = 1'b0;
    chk("jal.mispredict", mispredict_o, 1'b0);
    tick();
    chk("jal.commit", commit_history_o, 8'hF9);

    // Reset mid-run; training held through INIT, including the INIT->RUN edge, must be dropped.
    @(negedge clk_i) rst = 1'b1;
    F_PC_i = 32'h40; F_history_i = '0;
    #1;
    chk("rerst.commit", commit_history_o, 8'h00);
    chk("rerst.init_done", init_done_o, 1'b0);
    chk("rerst.predict", F_predict_o, 1'b0);
    tick();
    @(negedge clk_i) rst = 1'b0;
    set_train(1'b0, 32'h40, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (256) @(posedge clk_i);
    #1;
    MD_train_vaild_i = 1'b0;
    chk("reinit.done", init_done_o, 1'b1);
    chk("reinit.no_capture", mispredict_o, 1'b0);
    tick();
    chk("reinit.commit", commit_history_o, 8'h00);
    lookup(32'h40, 8'h00, "reinit", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_train_unit.md
# branch_train_unit

Writeback-side consumer of the MEM/WB branch-training fields. It owns the tournament predictor state: local PHT, global PHT, choice table and committed global history. It applies one training update per cycle from retiring branches and serves a combinational lookup port to fetch. It also flags mispredicts and emits repaired history so the fetch stage can resteer its speculative history.

## Interface
- IDX_W, 8, table index width; each table has 2^IDX_W 2-bit counters
- HIST_W, 8, global history width
- PC_W, 32, PC width
- clk_i  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- MD_train_vaild_i  in  1  retiring instruction is a conditional branch or jal with training data
- MD_jal_i  in  1  retiring instruction is jal; no counter or history update
- MD_train_taken_i  in  1  resolved direction
- MD_train_predict_i  in  1  final prediction used at fetch
- MD_train_global_predict_i  in  1  global component prediction at fetch
- MD_train_local_predict_i  in  1  local component prediction at fetch
- MD_train_global_history_i  in  HIST_W  speculative history used at fetch
- MD_PC_i  in  PC_W  branch PC
- F_PC_i  in  PC_W  fetch lookup PC
- F_history_i  in  HIST_W  fetch speculative history
- F_predict_o  out  1  final prediction
- F_global_predict_o, F_local_predict_o  out  1 each  component predictions
- init_done_o  out  1  tables initialised
- mispredict_o  out  1  one-cycle pulse: trained branch mispredicted
- recover_history_o  out  HIST_W  repaired history, valid with mispredict_o
- commit_history_o  out  HIST_W  committed global history register

## Operation
- Indices:
  - lidx = PC[IDX_W+1:2]
  - gidx = PC[IDX_W+1:2] XOR hist, with hist zero-extended or truncated to IDX_W
  - cidx = lidx
- Counters are 2-bit saturating.
  - Local and global PHT predict taken when the counter is >= 2.
  - Choice counter >= 2 selects global, else local.
- FSM states INIT and RUN.
  - Reset enters INIT with the init counter at 0.
  - In INIT, one entry per table is written per cycle at the init counter: local and global PHT get 2'b01, choice gets 2'b10.
  - After entry 2^IDX_W-1 is written, the FSM moves to RUN and init_done_o rises.
  - In INIT, all F_* outputs are 0 and training inputs are ignored.
- Training (RUN, MD_train_vaild_i=1, MD_jal_i=0), sampled at edge T. Request register U1 is valid during cycle T..T+1.
  - In U1, read the counters at lidx/gidx/cidx. gidx uses MD_train_global_history_i.
  - Local and global PHT: increment if taken, else decrement, saturating.
  - Choice: g_ok = global_predict==taken, l_ok = local_predict==taken.
    - g_ok & ~l_ok: increment.
    - ~g_ok & l_ok: decrement.
    - Otherwise unchanged.
  - Writes happen at the end of the U1 cycle.
  - commit_history_o <= {commit_history_o[HIST_W-2:0], taken} at the same edge.
- Mispredict: if U1 is valid and predict != taken, mispredict_o=1 for the U1 cycle.
  - recover_history_o = {MD_train_global_history_i[HIST_W-2:0], taken} as captured in U1.
  - recover_history_o is 0 when mispredict_o is 0.
- jal with valid: U1 is not loaded; nothing changes.
- Lookup forwarding: when U1 is valid and F's index equals U1's index for a table, the lookup uses U1's new counter value instead of the array value.

## Timing
- Reset values:
  - init_done_o 0, mispredict_o 0, recover_history_o 0, commit_history_o 0, F_* 0
  - U1 invalid, FSM INIT, init counter 0
- Init takes exactly 2^IDX_W cycles after rst deasserts. init_done_o is 1 from the following cycle.
- Training throughput is 1 per cycle. Latency from the sampling edge to the array write is 1 edge.
- Back-to-back trainings to the same index are correct with no stall. The second request reads the array after the first has been written.
- The lookup port is purely combinational from F_* inputs and current state, with forwarding as above.
- rst asserted mid-INIT or mid-RUN immediately:
  - returns to INIT at counter 0
  - clears U1, history and all outputs
  - table contents are re-initialised afterwards.
- Valid training on the same cycle as the INIT->RUN transition is dropped.

## Test plan
- Reset, IDX_W=8:
  - init_done_o stays 0 for 256 cycles, then 1.
  - Lookup any PC with history 0 -> F_local_predict_o=0, F_global_predict_o=0, F_predict_o=0, since choice=2 selects global.
- Train PC=0x40, history 0, taken=1, predict=0, global_predict=0, local_predict=0:
  - mispredict_o pulses 1 cycle.
  - recover_history_o=0x01, commit_history_o=0x01.
  - Lookup PC=0x40, history 0 -> global counter 2 -> F_predict_o=1.
- Saturation: train the same PC taken 5 times back-to-back -> local counter reaches 3 and stays 3. Then 1 not-taken -> counter 2, predict still 1.
- Choice: global_predict=1, local_predict=0, taken=1 at PC=0x80 -> choice 2->3. Then global 0, local 1, taken 1 twice -> choice 1, selects local.
- Lookup forwarding: with U1 training PC=0x40 (counter 1->2), drive F_PC_i=0x40 in the same cycle -> F_local_predict_o=1.
- jal with valid=1 -> no mispredict_o, history unchanged. Then rst mid-RUN -> commit_history_o=0, init_done_o=0, full re-init.
